// File: rtl/csa_design_if.sv
// Operand/result bundle for the registered carry-select adder.
// The master drives the operands and the carry-in. The slave (the adder)
// returns the registered sum and carry-out.
interface csa_design_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/csa_design.sv
// Registered carry-select adder: {cout,sum} <= a + b + cin, one cycle latency.
// Block 0 is a single ripple adder fed by cin. Every higher block computes
// two ripple results, one for carry-in 0 and one for carry-in 1. The carry
// out of the block below then selects between those two results.
// There is no handshake: new operands are accepted on every clock edge.
module csa_design #(
    parameter int WIDTH = 4,
    parameter int BLOCK = 2
) (
    input  logic         clk,
    input  logic         rst,
    csa_design_if.slave  bus
);
    localparam int NB = (BLOCK > 0) ? (WIDTH / BLOCK) : 1;

    // Reject block sizes that do not tile the operand width.
    if (BLOCK < 1 || WIDTH < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
        $error("csa_design: WIDTH must be a nonzero multiple of BLOCK");
    end

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_core;
    logic [NB:0]      blk_c;      // blk_c[k] is the carry into block k

    assign a_in     = bus.a;
    assign b_in     = bus.b;
    assign blk_c[0] = bus.cin;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [BLOCK-1:0] s0;
        logic [BLOCK-1:0] s1;
        logic             c0;
        logic             c1;

        if (k == 0) begin : g_first
            // Single ripple chain fed directly by the external carry-in.
            always_comb begin
                logic r;
                r  = blk_c[0];
                s0 = '0;
                for (int i = 0; i < BLOCK; i++) begin
                    s0[i] = a_in[i] ^ b_in[i] ^ r;
                    r     = (a_in[i] & b_in[i]) | (r & (a_in[i] ^ b_in[i]));
                end
                c0 = r;
            end
            assign s1        = s0;
            assign c1        = c0;
            assign sum_core[BLOCK-1:0] = s0;
            assign blk_c[1]  = c0;
        end else begin : g_sel
            // Two speculative ripple chains, one per possible carry-in.
            always_comb begin
                logic r0;
                logic r1;
                logic ai;
                logic bi;
                r0 = 1'b0;
                r1 = 1'b1;
                s0 = '0;
                s1 = '0;
                for (int i = 0; i < BLOCK; i++) begin
                    ai    = a_in[k*BLOCK + i];
                    bi    = b_in[k*BLOCK + i];
                    s0[i] = ai ^ bi ^ r0;
                    s1[i] = ai ^ bi ^ r1;
                    r0    = (ai & bi) | (r0 & (ai ^ bi));
                    r1    = (ai & bi) | (r1 & (ai ^ bi));
                end
                c0 = r0;
                c1 = r1;
            end
            assign sum_core[k*BLOCK +: BLOCK] = blk_c[k] ? s1 : s0;
            assign blk_c[k+1]                 = blk_c[k] ? c1 : c0;
        end
    end

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    // Next-state values: cleared under reset, otherwise the core result.
    always_comb begin
        sum_d  = sum_core;
        cout_d = blk_c[NB];
        if (rst) begin
            sum_d  = '0;
            cout_d = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_csa_design.sv
// Directed and exhaustive checks of the registered carry-select adder at
// WIDTH=4/BLOCK=2, plus random vectors on a WIDTH=8/BLOCK=4 instance.
module tb_csa_design;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [8:0] exp_q[$];

    csa_design_if #(.WIDTH(4)) if4 ();
    csa_design_if #(.WIDTH(8)) if8 ();

    csa_design #(.WIDTH(4), .BLOCK(2)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    csa_design #(.WIDTH(8), .BLOCK(4)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard compare
    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive the 4-bit DUT for one edge, then sample 1 time unit later
    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic r);
        if4.a   = a;
        if4.b   = b;
        if4.cin = c;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] res4();
        return {4'b0, if4.cout, if4.sum};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        if8.a    = '0;
        if8.b    = '0;
        if8.cin  = 1'b0;

        // 1. reset for two edges with all-ones inputs
        step4(4'hF, 4'hF, 1'b1, 1'b1);
        check("rst_edge1", res4(), 9'h000);
        check("rst_edge1_w8", {if8.cout, if8.sum}, 9'h000);
        step4(4'hF, 4'hF, 1'b1, 1'b1);
        check("rst_edge2", res4(), 9'h000);

        // 2. cin=0
        step4(4'h9, 4'h1, 1'b0, 1'b0);
        check("9+1+0", res4(), 9'h00A);
        step4(4'h8, 4'h0, 1'b0, 1'b0);
        check("8+0+0", res4(), 9'h008);

        // 3. cin=1
        step4(4'h9, 4'h1, 1'b1, 1'b0);
        check("9+1+1", res4(), 9'h00B);
        step4(4'h8, 4'h0, 1'b1, 1'b0);
        check("8+0+1", res4(), 9'h009);

        // 4. carry chains across blocks
        step4(4'hF, 4'h0, 1'b1, 1'b0);
        check("F+0+1", res4(), 9'h010);
        step4(4'h7, 4'h1, 1'b0, 1'b0);
        check("7+1+0", res4(), 9'h008);
        step4(4'hF, 4'hF, 1'b1, 1'b0);
        check("full_wrap", res4(), 9'h01F);
        step4(4'h0, 4'h0, 1'b0, 1'b0);
        check("zero", res4(), 9'h000);
        step4(4'h3, 4'h1, 1'b0, 1'b0);
        check("3+1+0", res4(), 9'h004);

        // 5a. exhaustive WIDTH=4
        for (int v = 0; v < 512; v++) begin
            logic [3:0] va;
            logic [3:0] vb;
            logic       vc;
            va = v[8:5];
            vb = v[4:1];
            vc = v[0];
            exp_q.push_back({4'b0, 5'(va) + 5'(vb) + 5'(vc)});
            step4(va, vb, vc, 1'b0);
            check("exh4", res4(), exp_q.pop_front());
        end

        // 5b. random WIDTH=8, BLOCK=4 (plus its extremes)
        for (int n = 0; n < 202; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            if (n == 0) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
            if (n == 1) begin ra = 8'hFF; rb = 8'h00; rc = 1'b1; end
            exp_q.push_back(9'(ra) + 9'(rb) + 9'(rc));
            if8.a   = ra;
            if8.b   = rb;
            if8.cin = rc;
            @(posedge clk);
            #1;
            check("rand8", {if8.cout, if8.sum}, exp_q.pop_front());
        end

        // 6. reset mid-stream
        step4(4'h9, 4'h1, 1'b1, 1'b0);
        check("stream_pre", res4(), 9'h00B);
        step4(4'h9, 4'h1, 1'b1, 1'b1);
        check("mid_rst", res4(), 9'h000);
        check("mid_rst_w8", {if8.cout, if8.sum}, 9'h000);
        step4(4'h9, 4'h1, 1'b1, 1'b0);
        check("post_rst", res4(), 9'h00B);
        step4(4'h9, 4'h1, 1'b1, 1'b0);
        check("hold", res4(), 9'h00B);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
